// File: rtl/cache_refill_ctrl.sv
// Miss-handling controller between a CPU load port, a direct-mapped block cache
// and a word-wide main memory; hits are served from the cache, misses refill a whole block.
module cache_refill_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int WORD_W  = 32,
  parameter int WORDS   = 4,
  parameter int BLOCK_W = WORDS * WORD_W,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cpu_req,
  input  logic [ADDR_W-1:0]  cpu_addr,
  output logic               cpu_ack,
  output logic [WORD_W-1:0]  cpu_data,
  output logic [ADDR_W-1:0]  cache_addr,
  output logic               cache_read,
  output logic [BLOCK_W-1:0] cache_fill,
  input  logic               cache_hit,
  input  logic [WORD_W-1:0]  cache_dout,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_ack,
  input  logic [WORD_W-1:0]  mem_data,
  output logic               busy,
  output logic [CNT_W-1:0]   hit_count,
  output logic [CNT_W-1:0]   miss_count,
  output logic [2:0]         state_dbg
);

  localparam int OFF_W = $clog2(WORDS);
  localparam int LSB   = OFF_W + 2;

  // Handshakes: cpu_req is held with cpu_addr until the one-cycle cpu_ack pulse;
  // mem_req/mem_addr stay stable until a cycle with mem_ack=1 consumes the word.
  typedef enum logic [2:0] {IDLE, LOOKUP, CHECK, REFILL, FILL, RESPOND} state_t;

  state_t             state;
  logic [OFF_W-1:0]   cnt;
  logic [OFF_W-1:0]   cnt_inc;
  logic [BLOCK_W-1:0] blk_q;
  logic [BLOCK_W-1:0] blk_next;
  logic [WORD_W-1:0]  fill_word;

  assign state_dbg = state;

  // blk_next already holds the word arriving this cycle, so the final ack can
  // write the complete block and pick the CPU word without a cache re-read.
  always_comb begin
    cnt_inc  = cnt + 1'b1;
    blk_next = blk_q;
    blk_next[cnt*WORD_W +: WORD_W] = mem_data;
    fill_word = blk_next[cache_addr[LSB-1:2]*WORD_W +: WORD_W];
  end

  // cache_addr doubles as the latched request address for the whole transaction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      blk_q      <= '0;
      cpu_ack    <= 1'b0;
      cpu_data   <= '0;
      cache_addr <= '0;
      cache_read <= 1'b1;
      cache_fill <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      busy       <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      cpu_ack    <= 1'b0;
      cache_read <= 1'b1;
      case (state)
        IDLE: begin
          if (cpu_req) begin
            cache_addr <= cpu_addr;
            busy       <= 1'b1;
            state      <= LOOKUP;
          end
        end
        LOOKUP: state <= CHECK;
        CHECK: begin
          // An unknown hit flag is treated as a miss.
          if (cache_hit === 1'b1) begin
            cpu_data <= cache_dout;
            cpu_ack  <= 1'b1;
            if (hit_count != {CNT_W{1'b1}}) hit_count <= hit_count + 1'b1;
            state    <= RESPOND;
          end else begin
            if (miss_count != {CNT_W{1'b1}}) miss_count <= miss_count + 1'b1;
            cnt      <= '0;
            mem_req  <= 1'b1;
            mem_addr <= {cache_addr[ADDR_W-1:LSB], {OFF_W{1'b0}}, 2'b00};
            state    <= REFILL;
          end
        end
        REFILL: begin
          if (mem_req && mem_ack) begin
            blk_q <= blk_next;
            cnt   <= cnt_inc;
            if (cnt == OFF_W'(WORDS - 1)) begin
              mem_req    <= 1'b0;
              cache_read <= 1'b0;
              cache_fill <= blk_next;
              cpu_data   <= fill_word;
              state      <= FILL;
            end else begin
              mem_addr <= {cache_addr[ADDR_W-1:LSB], cnt_inc, 2'b00};
            end
          end
        end
        FILL: begin
          cpu_ack <= 1'b1;
          state   <= RESPOND;
        end
        RESPOND: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Bench for cache_refill_ctrl: behavioural cache and memory around the DUT, with a
// transaction-level reference model of hits, misses, latency and counters.
module tb_cache_refill_ctrl;

  localparam int CW = 4;
  localparam logic [CW-1:0] CMAX = '1;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req;
  logic [31:0]   cpu_addr;
  logic          cpu_ack;
  logic [31:0]   cpu_data;
  logic [31:0]   cache_addr;
  logic          cache_read;
  logic [127:0]  cache_fill;
  logic          cache_hit;
  logic [31:0]   cache_dout;
  logic          mem_req;
  logic [31:0]   mem_addr;
  logic          mem_ack = 1'b0;
  logic [31:0]   mem_data = '0;
  logic          busy;
  logic [CW-1:0] hit_count;
  logic [CW-1:0] miss_count;
  logic [2:0]    state_dbg;

  always #5 clk = ~clk;

  cache_refill_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_ack(cpu_ack), .cpu_data(cpu_data), .cache_addr(cache_addr),
    .cache_read(cache_read), .cache_fill(cache_fill), .cache_hit(cache_hit),
    .cache_dout(cache_dout), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_data(mem_data), .busy(busy),
    .hit_count(hit_count), .miss_count(miss_count), .state_dbg(state_dbg)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    case (w)
      32'h100: return 32'h11;
      32'h104: return 32'h22;
      32'h108: return 32'h33;
      32'h10C: return 32'h44;
      default: return {~w[15:0], w[15:0]} ^ 32'h1357_2468;
    endcase
  endfunction

  function automatic logic [127:0] block_of(input logic [31:0] a);
    logic [127:0] b;
    for (int i = 0; i < 4; i++) b[32*i +: 32] = mem_word({a[31:4], 4'b0} + 32'(4 * i));
    return b;
  endfunction

  // Behavioural direct-mapped cache: 8 blocks, lookup result valid the cycle after.
  logic [7:0]   cv = '0;
  logic [24:0]  ctag [8];
  logic [127:0] cdat [8];
  logic         hit_q = 1'b0;
  logic [31:0]  dout_q = '0;
  logic         x_inj = 1'b0;

  always @(posedge clk) begin
    if (!cache_read) begin
      cv[cache_addr[6:4]]   <= 1'b1;
      ctag[cache_addr[6:4]] <= cache_addr[31:7];
      cdat[cache_addr[6:4]] <= cache_fill;
    end else begin
      hit_q  <= cv[cache_addr[6:4]] && (ctag[cache_addr[6:4]] == cache_addr[31:7]);
      dout_q <= cdat[cache_addr[6:4]][32*cache_addr[3:2] +: 32];
    end
  end

  assign cache_hit  = x_inj ? 1'bx : hit_q;
  assign cache_dout = dout_q;

  // Reference model state
  logic [7:0]    rv = '0;
  logic [24:0]   rtag [8];
  logic [CW-1:0] m_hits = '0;
  logic [CW-1:0] m_miss = '0;
  logic [31:0]   exp_q [$];
  logic [CW-1:0] exp_hits_q [$];
  logic [CW-1:0] exp_miss_q [$];

  logic [31:0]  cur_addr = '0;
  int           wait_cfg = 0;
  int           words_acked = 0;
  int           fills = 0;
  logic [127:0] last_fill = '0;

  // Memory responder: acks each word wait_cfg cycles after it is first requested.
  logic        in_word = 1'b0;
  int          wl = 0;
  logic [31:0] word_addr = '0;

  always @(negedge clk) begin
    if (reset || !mem_req) begin
      mem_ack  = 1'b0;
      in_word  = 1'b0;
      mem_data = $urandom;
    end else begin
      if (!in_word) begin
        in_word   = 1'b1;
        wl        = wait_cfg;
        word_addr = mem_addr;
        check("mem_addr_seq", mem_addr, {cur_addr[31:4], 4'b0} + 32'(4 * words_acked));
      end else begin
        check("mem_addr_hold", mem_addr, word_addr);
      end
      if (wl == 0) begin
        mem_ack  = 1'b1;
        mem_data = mem_word(mem_addr);
        in_word  = 1'b0;
        words_acked++;
      end else begin
        mem_ack  = 1'b0;
        mem_data = $urandom;
        wl--;
      end
    end
  end

  // Compare process: block writes and CPU responses against the model.
  always @(negedge clk) begin
    if (!reset) begin
      if (!cache_read) begin
        fills++;
        last_fill = cache_fill;
        check("fill_addr", cache_addr[31:4], cur_addr[31:4]);
        check("fill_block", cache_fill, block_of(cur_addr));
      end
      if (cpu_ack) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ack", 1, 0);
        end else begin
          check("cpu_data", cpu_data, exp_q.pop_front());
          check("hit_count", hit_count, exp_hits_q.pop_front());
          check("miss_count", miss_count, exp_miss_q.pop_front());
        end
      end
    end
  end

  task automatic do_read(input logic [31:0] addr, input int waits, input bit hold,
                         input bit xin, output logic [31:0] data, output int lat);
    int idx;
    bit hit;
    int exp_lat;
    int cyc;
    bit got;
    idx = int'(addr[6:4]);
    hit = rv[idx] && (rtag[idx] == addr[31:7]) && !xin;
    if (hit) begin
      m_hits = (m_hits == CMAX) ? CMAX : m_hits + 1'b1;
    end else begin
      m_miss    = (m_miss == CMAX) ? CMAX : m_miss + 1'b1;
      rv[idx]   = 1'b1;
      rtag[idx] = addr[31:7];
    end
    exp_lat = hit ? 3 : 8 + 4 * waits;
    exp_q.push_back(mem_word(addr));
    exp_hits_q.push_back(m_hits);
    exp_miss_q.push_back(m_miss);

    @(posedge clk);
    #1;
    cur_addr    = addr;
    wait_cfg    = waits;
    words_acked = 0;
    fills       = 0;
    x_inj       = xin;
    cpu_addr    = addr;
    cpu_req     = 1'b1;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc <= 200) begin
      @(negedge clk);
      check("ctrl_busy_memreq_read", {busy, mem_req, cache_read},
            {cyc > 0, !hit && cyc >= 3 && cyc <= exp_lat - 2, !(!hit && cyc == exp_lat - 1)});
      if (cpu_ack) got = 1'b1;
      else cyc++;
    end
    if (!got) check("ack_timeout", 0, 1);
    check("latency", cyc, exp_lat);
    check("mem_words", words_acked, hit ? 0 : 4);
    check("fills", fills, hit ? 0 : 1);
    data  = cpu_data;
    lat   = cyc;
    x_inj = 1'b0;
    if (!hold) cpu_req = 1'b0;
  endtask

  task automatic abort_read(input logic [31:0] addr, input int nwords);
    int n;
    @(posedge clk);
    #1;
    cur_addr    = addr;
    wait_cfg    = 1;
    words_acked = 0;
    fills       = 0;
    cpu_addr    = addr;
    cpu_req     = 1'b1;
    n = 0;
    while (words_acked < nwords && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (words_acked < nwords) check("abort_timeout", words_acked, nwords);
    @(posedge clk);
    #2;
    reset   = 1'b1;
    cpu_req = 1'b0;
    #1;
    check("rst_mid_ctrl", {mem_req, busy, cache_read, cpu_ack}, 4'b0010);
    check("rst_mid_counts", {hit_count, miss_count}, 0);
    check("abort_no_fill", fills, 0);
    check("abort_words", words_acked, nwords);
    m_hits = '0;
    m_miss = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  logic [31:0] d;
  int          l;
  logic [31:0] a;
  bit          h;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    cpu_req  = 1'b0;
    cpu_addr = '0;
    repeat (3) @(negedge clk);
    check("reset_outs", {cpu_ack, cpu_data, cache_addr, cache_read, mem_req, mem_addr, busy},
          {1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0});
    check("reset_fill", cache_fill, 0);
    check("reset_counts", {hit_count, miss_count}, 0);
    reset = 1'b0;

    // Cold miss, then a hit in the same block
    do_read(32'h104, 0, 0, 0, d, l);
    check("t2_data", d, 32'h22);
    check("t2_lat", l, 8);
    check("t2_fill", last_fill, 128'h00000044_00000033_00000022_00000011);
    check("t2_miss", miss_count, 1);
    do_read(32'h10C, 0, 0, 0, d, l);
    check("t3_data", d, 32'h44);
    check("t3_lat", l, 3);
    check("t3_hit", hit_count, 1);

    // Conflict on index 0, then the evicted block misses again
    do_read(32'h184, 0, 0, 0, d, l);
    check("t4_lat", l, 8);
    do_read(32'h104, 0, 0, 0, d, l);
    check("t4_again_lat", l, 8);

    // Three memory wait cycles per word
    do_read(32'h188, 3, 0, 0, d, l);
    check("t5_lat", l, 20);

    // Unknown hit flag on an address that is present must refill
    do_read(32'h184, 0, 0, 1, d, l);
    check("xhit_lat", l, 8);

    // Abort a refill after two words, then the same read refills from word 0
    abort_read(32'h200, 2);
    do_read(32'h200, 0, 0, 0, d, l);
    check("t6_lat", l, 8);

    for (int i = 0; i < 40; i++) begin
      a = 32'h1000 | 32'($urandom_range(0, 15) << 4) | 32'($urandom_range(0, 15));
      h = (i != 39) && ($urandom_range(0, 1) == 1);
      do_read(a, $urandom_range(0, 2), h, 0, d, l);
    end

    for (int i = 0; i < 20; i++) do_read(32'h1004, 0, 0, 0, d, l);
    check("hit_saturated", hit_count, 4'hF);
    for (int i = 0; i < 16; i++) do_read((i % 2 == 0) ? 32'h2000 : 32'h2080, 0, 0, 0, d, l);
    check("miss_saturated", miss_count, 4'hF);

    repeat (3) @(negedge clk);
    check("exp_q_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
